// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default link parameters.
// Used by uart_tx now and by the receive side later.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream valid/ready handshake between a producer and the UART transmitter.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_baud_counter.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte over valid/ready and shifts it out
// LSB first between a low start bit and a high stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   s,
  output logic       tx,
  output logic       busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_d;
  logic                 tick;
  logic                 accept;

  // Counter is held at zero while idle, so the start bit gets a full period.
  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  assign s.tx_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = s.tx_valid && s.tx_ready;

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = START;
          shift_d = s.tx_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Reset wins over a same-edge handshake, dropping that byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that converts a parallel byte, accepted through a valid/ready handshake, into an 8N1 asynchronous frame on a single wire. It is the transmit end of the board's UART link and sits between fabric logic producing bytes and the FPGA TX pin. The bit period is a fixed number of clock cycles set by parameter. All state and the serial output are registered.

## Interface
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2
- DATA_BITS, 8, payload bits per frame
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  reset reset, synchronous, active-high; clock clk
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake
- tx_valid  input  1  producer has a byte
- tx_ready  output  1  transmitter idle, can accept; high exactly when state is IDLE
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress (state ≠ IDLE)

## Operation
- Handshake: a transfer occurs on a rising edge where tx_valid && tx_ready are both 1. tx_data is latched into a shift register on that edge; later changes of tx_data are ignored.
- tx_valid without tx_ready: no effect, no error. The producer holds data until the transfer.
- FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: tx=1. On transfer: go to START, clear baud counter, tx=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and tx=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. The shift register shifts right at the end of each bit. After bit DATA_BITS-1: go to STOP, tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT). No terminal-count overflow.
- Bit index width is $clog2(DATA_BITS). Wrap-around is not used; the index is compared against DATA_BITS-1.
- Reset values, applied on the next edge with reset=1: state=IDLE, tx=1, tx_ready=1, busy=0, counters=0, shift register=0.
- Reset mid-frame aborts the frame. tx returns high on that edge, and no partial resumption occurs.
- Reset and handshake on the same edge: reset wins and the byte is dropped.

## Timing
- Transfer on edge k: tx is low from edge k.
- Data bit i is on tx from edge k+(1+i)·N to k+(2+i)·N, where N=CLKS_PER_BIT.
- Stop bit runs from k+9·N to k+10·N for the default DATA_BITS=8.
- State returns to IDLE and tx_ready rises at edge k+10·N.
- The earliest next transfer is edge k+10·N+1, so the back-to-back frame period is 10·N+1 cycles.
- Minimum gap between frames is 1 cycle of idle-high, which is legal for 8N1.
- tx, busy and tx_ready change only on clock edges. tx_ready and busy are decoded from the state register and have no combinational path from inputs.

## Structure
- Shared package uart_pkg holds:
  - the state typedef enum {IDLE, START, DATA, STOP};
  - constant DEFAULT_CLKS_PER_BIT=868;
  - constant UART_DATA_BITS=8.
- A future uart_rx shares the same package.
- One sub-module: baud_counter. It takes parameter CLKS_PER_BIT and ports clk, reset, clear, tick. tick is 1 on the last cycle of a bit.
- The FSM, shift register and bit index stay in uart_tx.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset then idle 20 cycles → tx=1, tx_ready=1, busy=0 throughout.
- Send 0xA5 with a one-cycle tx_valid → tx samples, one per 4-cycle bit, read 0,1,0,1,0,0,1,0,1,1. tx_ready is low for exactly 40 cycles and high again at edge k+40.
- Hold tx_valid high with 0x00 then 0xFF → two transfers 41 cycles apart. The second frame's start bit follows exactly 1 idle-high cycle after the first stop bit.
- Change tx_data to 0x3C mid-frame after a 0x81 transfer → the wire still shows 0x81 (LSB first: 1,0,0,0,0,0,0,1).
- Assert reset during data bit 3 → tx=1, busy=0, tx_ready=1 on the next edge. A new 0x55 then sends a complete, correct frame.
- Assert tx_valid on the same edge as reset → no frame; tx stays 1 for 40 cycles after reset.
